// File: rtl/tx_burst_pkg.sv
// Shared constants, state encoding and training-sequence table for the
// normal-burst formatter.
package tx_burst_pkg;

  localparam int TAIL_BITS      = 3;
  localparam int HALF_DATA_BITS = 58;
  localparam int TRAIN_BITS     = 26;
  localparam int GUARD_BITS     = 8;
  localparam int TOTAL_SYMBOLS  = 2*TAIL_BITS + 2*HALF_DATA_BITS + TRAIN_BITS + GUARD_BITS;

  // First symbol index of each phase; IDX_DONE marks "all symbols emitted".
  localparam logic [7:0] IDX_DATA_A   = 8'(TAIL_BITS);
  localparam logic [7:0] IDX_TRAIN    = 8'(TAIL_BITS + HALF_DATA_BITS);
  localparam logic [7:0] IDX_DATA_B   = 8'(TAIL_BITS + HALF_DATA_BITS + TRAIN_BITS);
  localparam logic [7:0] IDX_END_TAIL = 8'(TAIL_BITS + 2*HALF_DATA_BITS + TRAIN_BITS);
  localparam logic [7:0] IDX_GUARD    = 8'(2*TAIL_BITS + 2*HALF_DATA_BITS + TRAIN_BITS);
  localparam logic [7:0] IDX_DONE     = 8'(TOTAL_SYMBOLS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HEAD_TAIL, ST_DATA_A, ST_TRAIN, ST_DATA_B, ST_END_TAIL, ST_GUARD
  } state_e;

  // GSM normal-burst training sequences, bit 25 transmitted first.
  localparam logic [TRAIN_BITS-1:0] TSC_TABLE [8] = '{
    26'h0970897, 26'h0B778B7, 26'h10EE90E, 26'h11ED11E,
    26'h06B906B, 26'h13AC13A, 26'h29F629F, 26'h3BC4BBC
  };

  function automatic state_e phase_of(input logic [7:0] idx);
    if (idx < IDX_DATA_A)        return ST_HEAD_TAIL;
    else if (idx < IDX_TRAIN)    return ST_DATA_A;
    else if (idx < IDX_DATA_B)   return ST_TRAIN;
    else if (idx < IDX_END_TAIL) return ST_DATA_B;
    else if (idx < IDX_GUARD)    return ST_END_TAIL;
    else                         return ST_GUARD;
  endfunction

endpackage

// File: rtl/tx_symbol_edge.sv
// Registers the modulator strobe and emits a one-clock pulse on its rising edge,
// so a strobe held high for several clocks advances the burst only once.
module tx_symbol_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe,
  output logic sym_ev
);

  logic strobe_q, strobe_d;

  always_comb strobe_d = strobe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) strobe_q <= 1'b0;
    else          strobe_q <= strobe_d;
  end

  assign sym_ev = strobe & ~strobe_q;

endmodule

// File: rtl/tx_burst_formatter.sv
// Normal-burst builder: tail/payload/training/guard sequencing, one-entry
// payload hold register and differential encoding toward the GMSK modulator.
module tx_burst_formatter
  import tx_burst_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       next_symbol_strobe,
  output logic       current_symbol,
  input  logic       start,
  input  logic [2:0] tsc,
  output logic       busy,
  output logic       burst_done,
  input  logic       payload_bit,
  input  logic       payload_valid,
  output logic       payload_ready,
  output logic       underrun
);

  logic sym_ev;

  tx_symbol_edge u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe  (next_symbol_strobe),
    .sym_ev  (sym_ev)
  );

  state_e                state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic [TRAIN_BITS-1:0] train_q, train_d;
  logic                  prev_raw_q, prev_raw_d;
  logic                  cur_sym_q, cur_sym_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  under_q, under_d;
  logic                  hold_full_q, hold_full_d;
  logic                  hold_bit_q, hold_bit_d;
  logic                  ready_q, ready_d;
  logic                  raw;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    train_d     = train_q;
    prev_raw_d  = prev_raw_q;
    cur_sym_d   = cur_sym_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    under_d     = 1'b0;
    hold_full_d = hold_full_q;
    hold_bit_d  = hold_bit_q;
    raw         = 1'b0;

    // Fill is independent of burst state so the first bit can be prefetched.
    if (payload_valid && ready_q) begin
      hold_full_d = 1'b1;
      hold_bit_d  = payload_bit;
    end

    if (state_q == ST_IDLE) begin
      if (start) begin
        busy_d     = 1'b1;
        train_d    = TSC_TABLE[tsc];
        prev_raw_d = 1'b1;
        idx_d      = 8'd0;
        state_d    = ST_HEAD_TAIL;
      end
    end else if (sym_ev) begin
      if (idx_q == IDX_DONE) begin
        // Last guard symbol has had its full interval; release the line.
        cur_sym_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        if (state_q == ST_GUARD) begin
          raw = 1'b1;
        end else if (state_q == ST_TRAIN) begin
          raw     = train_q[TRAIN_BITS-1];
          train_d = {train_q[TRAIN_BITS-2:0], 1'b0};
        end else if (state_q == ST_DATA_A || state_q == ST_DATA_B) begin
          if (hold_full_q) begin
            raw         = hold_bit_q;
            hold_full_d = 1'b0;
          end else begin
            under_d = 1'b1;
          end
        end
        cur_sym_d  = raw ^ prev_raw_q;
        prev_raw_d = raw;
        idx_d      = idx_q + 8'd1;
        state_d    = phase_of(idx_d);
      end
    end

    ready_d = ~hold_full_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 8'd0;
      train_q     <= '0;
      prev_raw_q  <= 1'b1;
      cur_sym_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
      hold_full_q <= 1'b0;
      hold_bit_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      train_q     <= train_d;
      prev_raw_q  <= prev_raw_d;
      cur_sym_q   <= cur_sym_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      under_q     <= under_d;
      hold_full_q <= hold_full_d;
      hold_bit_q  <= hold_bit_d;
      ready_q     <= ready_d;
    end
  end

  assign current_symbol = cur_sym_q;
  assign busy           = busy_q;
  assign burst_done     = done_q;
  assign underrun       = under_q;
  assign payload_ready  = ready_q;

endmodule

// File: tb/tb_tx_burst_formatter.sv
// Directed bench for tx_burst_formatter: strobe every 20 clocks (high for 2),
// per-symbol expectations from a reference burst model, scenario tasks in sequence.
module tb_tx_burst_formatter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       next_symbol_strobe;
  logic       current_symbol;
  logic       start;
  logic [2:0] tsc;
  logic       busy;
  logic       burst_done;
  logic       payload_bit;
  logic       payload_valid;
  logic       payload_ready;
  logic       underrun;

  tx_burst_formatter dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .next_symbol_strobe (next_symbol_strobe),
    .current_symbol     (current_symbol),
    .start              (start),
    .tsc                (tsc),
    .busy               (busy),
    .burst_done         (burst_done),
    .payload_bit        (payload_bit),
    .payload_valid      (payload_valid),
    .payload_ready      (payload_ready),
    .underrun           (underrun)
  );

  always #5 clock = ~clock;

  logic [25:0] tsc_tab [0:7] = '{
    26'h0970897, 26'h0B778B7, 26'h10EE90E, 26'h11ED11E,
    26'h06B906B, 26'h13AC13A, 26'h29F629F, 26'h3BC4BBC
  };

  int total = 0;
  int bad   = 0;

  // payload source: budgeted, can be paused
  int   feed_left = 0;
  int   xfer_cnt  = 0;
  logic feed_val  = 1'b0;
  logic feed_hold = 1'b0;
  int   done_cnt  = 0;
  int   under_cnt = 0;

  always @(negedge clock) begin
    if (burst_done === 1'b1) done_cnt++;
    if (underrun === 1'b1) under_cnt++;
    if (feed_left > 0 && !feed_hold) begin
      payload_valid = 1'b1;
      payload_bit   = feed_val;
      if (payload_ready === 1'b1) begin
        feed_left--;
        xfer_cnt++;
      end
    end else begin
      payload_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  // per-burst observations
  logic obs [0:155];
  int   sym_err, busy_n;
  logic start_busy, end_busy, end_done, end_cur, chain_busy;
  logic rst_cur, rst_busy, rst_ready;
  bit   rst_hold_ok;

  function automatic logic model_raw(input int i, input logic [2:0] code,
                                     input logic pval, input int gap);
    logic [25:0] t;
    logic [4:0]  b;
    t = tsc_tab[code];
    if (i < 3 || (i >= 145 && i < 148)) return 1'b0;
    if (i >= 148) return 1'b1;
    if (i >= 61 && i < 87) begin
      b = 5'(86 - i);
      return t[b];
    end
    if (i == gap) return 1'b0;
    return pval;
  endfunction

  function automatic logic dec_raw(input int n);
    logic d;
    d = 1'b1;
    for (int i = 0; i <= n; i++) d = obs[i] ^ d;
    return d;
  endfunction

  function automatic logic [25:0] train_word();
    logic [25:0] w;
    w = '0;
    for (int i = 61; i < 87; i++) w = {w[24:0], dec_raw(i)};
    return w;
  endfunction

  task automatic run_burst(input logic [2:0] code, input logic pval, input int gap_idx,
                           input int poke_idx, input int rst_idx, input bit do_start,
                           input bit chain, input logic [2:0] chain_code);
    logic prev_raw, raw, exp_cur, exp_prev_cur;
    sym_err = 0;
    busy_n  = 0;
    if (do_start) begin
      @(negedge clock); start = 1'b1; tsc = code;
      @(negedge clock); start = 1'b0; tsc = ~code;
      start_busy = busy;
    end
    prev_raw     = 1'b1;
    exp_prev_cur = 1'b1;
    for (int i = 0; i < 156; i++) begin
      if (i == rst_idx) begin
        @(negedge clock); #3;
        reset_n   = 1'b0;
        feed_hold = 1'b1;
        #1;
        rst_cur   = current_symbol;
        rst_busy  = busy;
        rst_ready = payload_ready;
        repeat (3) @(negedge clock);
        rst_hold_ok = (current_symbol === 1'b1 && busy === 1'b0 && payload_ready === 1'b0);
        reset_n = 1'b1;
        return;
      end
      raw     = model_raw(i, code, pval, gap_idx);
      exp_cur = raw ^ prev_raw;
      @(negedge clock);
      if (i == gap_idx - 1) feed_hold = 1'b1;
      if (current_symbol !== exp_prev_cur) sym_err++;
      next_symbol_strobe = 1'b1;
      if (i == poke_idx) begin start = 1'b1; tsc = 3'd3; end
      @(negedge clock);
      obs[i] = current_symbol;
      if (current_symbol !== exp_cur) sym_err++;
      if (underrun !== (i == gap_idx)) sym_err++;
      if (busy === 1'b1) busy_n++;
      if (i == poke_idx) begin start = 1'b0; tsc = ~code; end
      @(negedge clock);
      if (current_symbol !== exp_cur || underrun !== 1'b0) sym_err++;
      next_symbol_strobe = 1'b0;
      if (i == gap_idx) feed_hold = 1'b0;
      repeat (17) @(negedge clock);
      prev_raw     = raw;
      exp_prev_cur = exp_cur;
    end
    // completion strobe
    @(negedge clock);
    if (current_symbol !== exp_prev_cur) sym_err++;
    next_symbol_strobe = 1'b1;
    if (chain) begin start = 1'b1; tsc = chain_code; end
    @(negedge clock);
    end_busy = busy; end_done = burst_done; end_cur = current_symbol;
    @(negedge clock);
    chain_busy = busy;
    start = 1'b0;
    tsc = ~chain_code;
    next_symbol_strobe = 1'b0;
    repeat (17) @(negedge clock);
  endtask

  task automatic test_reset();
    #12;
    total++; if (current_symbol !== 1'b1) begin bad++; $display("FAIL rst_cur: got %b want 1", current_symbol); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (burst_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", burst_done); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    total++; if (payload_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", payload_ready); end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    total++; if (payload_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %b want 1", payload_ready); end
  endtask

  task automatic test_zeros();
    int d0;
    xfer_cnt = 0; feed_val = 1'b0; feed_left = 116; d0 = done_cnt;
    run_burst(3'd0, 1'b0, -10, -1, -1, 1'b1, 1'b0, 3'd0);
    total++; if (start_busy !== 1'b1) begin bad++; $display("FAIL z_start_busy: got %b want 1", start_busy); end
    total++; if (sym_err !== 0) begin bad++; $display("FAIL z_symbols: got %0d errors want 0", sym_err); end
    total++; if (busy_n !== 156) begin bad++; $display("FAIL z_updates: got %0d want 156", busy_n); end
    total++; if (xfer_cnt !== 116) begin bad++; $display("FAIL z_xfers: got %0d want 116", xfer_cnt); end
    total++; if (obs[0] !== 1'b1 || obs[1] !== 1'b0) begin bad++; $display("FAIL z_first2: got %b%b want 10", obs[0], obs[1]); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL z_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (end_busy !== 1'b0 || end_done !== 1'b1 || end_cur !== 1'b1) begin
      bad++; $display("FAIL z_end: busy/done/cur got %b%b%b want 011", end_busy, end_done, end_cur); end
    total++; if (payload_ready !== 1'b1) begin bad++; $display("FAIL z_hold_empty: got %b want 1", payload_ready); end
  endtask

  task automatic test_ones_tsc5();
    int zeros;
    feed_val = 1'b1; feed_left = 116;
    run_burst(3'd5, 1'b1, -10, -1, -1, 1'b1, 1'b0, 3'd0);
    total++; if (sym_err !== 0) begin bad++; $display("FAIL o_symbols: got %0d errors want 0", sym_err); end
    total++; if (train_word() !== 26'h13AC13A) begin bad++; $display("FAIL o_train: got %h want 13ac13a", train_word()); end
    total++; if (obs[148] !== 1'b1) begin bad++; $display("FAIL o_guard_first: got %b want 1", obs[148]); end
    zeros = 0;
    for (int i = 149; i < 156; i++) if (obs[i] === 1'b0) zeros++;
    total++; if (zeros !== 7) begin bad++; $display("FAIL o_guard_zero: got %0d want 7", zeros); end
  endtask

  task automatic test_underrun();
    int u0;
    feed_val = 1'b1; feed_left = 115; u0 = under_cnt;
    run_burst(3'd2, 1'b1, 10, -1, -1, 1'b1, 1'b0, 3'd0);
    total++; if (under_cnt - u0 !== 1) begin bad++; $display("FAIL u_pulses: got %0d want 1", under_cnt - u0); end
    total++; if (dec_raw(10) !== 1'b0) begin bad++; $display("FAIL u_raw10: got %b want 0", dec_raw(10)); end
    total++; if (dec_raw(11) !== 1'b1) begin bad++; $display("FAIL u_raw11: got %b want 1", dec_raw(11)); end
    total++; if (sym_err !== 0) begin bad++; $display("FAIL u_symbols: got %0d errors want 0", sym_err); end
  endtask

  task automatic test_start_ignore();
    feed_val = 1'b0; feed_left = 116;
    run_burst(3'd1, 1'b0, -10, 50, -1, 1'b1, 1'b0, 3'd0);
    total++; if (train_word() !== 26'h0B778B7) begin bad++; $display("FAIL s_train: got %h want 0b778b7", train_word()); end
    total++; if (busy_n !== 156) begin bad++; $display("FAIL s_updates: got %0d want 156", busy_n); end
    total++; if (sym_err !== 0) begin bad++; $display("FAIL s_symbols: got %0d errors want 0", sym_err); end
  endtask

  task automatic test_done_start();
    feed_val = 1'b1; feed_left = 116;
    run_burst(3'd4, 1'b1, -10, -1, -1, 1'b1, 1'b1, 3'd7);
    total++; if (end_busy !== 1'b0 || end_done !== 1'b1) begin
      bad++; $display("FAIL d_ignored: busy/done got %b%b want 01", end_busy, end_done); end
    total++; if (chain_busy !== 1'b1) begin bad++; $display("FAIL d_restart: got %b want 1", chain_busy); end
    feed_left = 200;
  endtask

  task automatic test_reset_mid();
    run_burst(3'd7, 1'b1, -10, -1, 90, 1'b0, 1'b0, 3'd0);
    total++; if (sym_err !== 0) begin bad++; $display("FAIL r_pre_symbols: got %0d errors want 0", sym_err); end
    total++; if (rst_cur !== 1'b1 || rst_busy !== 1'b0 || rst_ready !== 1'b0) begin
      bad++; $display("FAIL r_async: cur/busy/ready got %b%b%b want 100", rst_cur, rst_busy, rst_ready); end
    total++; if (!rst_hold_ok) begin bad++; $display("FAIL r_held: got %b want 1", rst_hold_ok); end
    feed_left = 116; feed_val = 1'b1; feed_hold = 1'b0; xfer_cnt = 0;
    run_burst(3'd0, 1'b1, -10, -1, -1, 1'b1, 1'b0, 3'd0);
    total++; if (sym_err !== 0) begin bad++; $display("FAIL r_clean_symbols: got %0d errors want 0", sym_err); end
    total++; if (busy_n !== 156) begin bad++; $display("FAIL r_clean_updates: got %0d want 156", busy_n); end
    total++; if (xfer_cnt !== 116) begin bad++; $display("FAIL r_clean_xfers: got %0d want 116", xfer_cnt); end
  endtask

  initial begin
    reset_n = 1'b0; next_symbol_strobe = 1'b0; start = 1'b0; tsc = 3'd0;
    payload_bit = 1'b0; payload_valid = 1'b0;
    test_reset();
    test_zeros();
    test_ones_tsc5();
    test_underrun();
    test_start_ignore();
    test_done_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
